dcache_wb_buffer: RTL and testbench
===================================

// Module: dcache_wb_buffer
// PURPOSE
//  Victim/uncached-store buffer between the dcache write-back controller and the AXI write channels.
//  Captures one dirty line (LINE_WORDS words) or one uncached word in a single handshake, then drives AW, W and B.
//  Frees the cache pipeline as soon as the line is latched; the cache may refill while the buffer drains.
//  Exposes busy and the buffered line address so the cache can stall reads that hit the pending victim.
// PARAMETERS
//  ADDR_W      32  byte address width
//  DATA_W      32  AXI data / cache word width
//  LINE_WORDS  4   words per cache line; power of two, 2..16
//  AXI_ID      0   constant value driven on d_awid
// PORTS
//  clk          in   1                    clock, rising edge
//  rstn         in   1                    asynchronous active-low reset
//  wb_valid     in   1                    write request offered by cache
//  wb_ready     out  1                    buffer can accept (high only in IDLE)
//  wb_addr      in   ADDR_W               line base (cached) or word address (uncached)
//  wb_data      in   LINE_WORDS*DATA_W    line data, word 0 in bits [DATA_W-1:0]
//  wb_strb      in   DATA_W/8             byte strobe, used only when wb_uncache=1
//  wb_uncache   in   1                    1 = single-beat uncached store
//  wb_busy      out  1                    request held, not yet acknowledged on B
//  wb_busy_addr out  ADDR_W               latched address, line-aligned when cached
//  wb_done      out  1                    one-cycle pulse on B handshake
//  d_awvalid/d_awready  out/in  1         AW handshake
//  d_awaddr     out  ADDR_W               latched address
//  d_awlen      out  8                    uncache ? 0 : LINE_WORDS-1
//  d_awsize     out  3                    log2(DATA_W/8)
//  d_awburst    out  2                    uncache ? 2'b00 FIXED : 2'b01 INCR
//  d_awid       out  4                    AXI_ID
//  d_wvalid/d_wready    out/in  1         W handshake
//  d_wdata      out  DATA_W               current beat word
//  d_wstrb      out  DATA_W/8             uncache ? latched strb : all ones
//  d_wlast      out  1                    last beat of burst
//  d_bvalid/d_bready    in/out  1         B handshake
// BEHAVIOUR
//  - States IDLE, AW, W, B; Moore outputs decoded from state/counter registers, no input-to-output comb path.
//  - Reset (async, any state): state=IDLE, beat=0, latched regs=0; wb_ready=1, every other output 0.
//  - IDLE: wb_ready=1. wb_valid&&wb_ready latches addr/data/strb/uncache -> AW next cycle.
//    Cached requests latch wb_addr with low log2(LINE_WORDS*DATA_W/8) bits cleared.
//  - AW: d_awvalid=1 and held stable until d_awready; on handshake -> W, beat=0.
//  - W: d_wvalid=1, d_wdata=line[beat]; d_wlast = (beat==d_awlen[3:0]).
//    wvalid&&wready: wlast ? -> B : beat+1. No beat advances without wready; data stable while stalled.
//  - B: d_bready=1; d_bvalid -> IDLE, wb_done=1 for exactly that cycle; bresp ignored unless macro below.
//  - wb_busy = (state!=IDLE). Minimum latency accept->done = 3+N cycles with zero-wait slave (N beats).
//  - Next request accepted the cycle after wb_done (IDLE); no overlap of bursts.
//  - d_wready asserted during AW or B is ignored; d_bvalid before last W beat is ignored.
//  - Beat counter is log2(LINE_WORDS) bits; never wraps (exits at wlast).
// CONFIGURATION
//  WB_BRESP_CHECK_EN defined: adds input d_bresp[1:0] and output wb_err (1-cycle pulse with wb_done
//  when d_bresp!=2'b00); wb_err reset 0.
//  Undefined: neither port exists, response code ignored, behaviour otherwise identical.
// STRUCTURE
//  Shared package dcache_pkg: wb_state_t enum, AXI_BURST_FIXED/INCR, AXI_RESP_OKAY, AXI_SIZE_4B.
//  Single flat module; no sub-module (line register + 4-state FSM + beat counter).
// TESTING
//  1 cached line 0x1000_0040, data words 0x11,0x22,0x33,0x44, zero-wait slave -> awlen=3, INCR, awaddr=0x1000_0040, 4 beats in order, wlast on 0x44, done at cycle 7.
//  2 uncached store addr 0xBFD0_0004, strb=4'b0011 -> awlen=0, FIXED, one beat, wstrb=0011, wlast on first beat.
//  3 wready toggled 1,0,0,1,... and awready delayed 5 cycles -> wdata/awaddr stable while stalled, no skipped/duplicated beat.
//  4 rstn pulled low mid-W (beat 2) -> outputs 0 immediately, wb_ready=1; new request afterwards completes normally.
//  5 wb_valid held high back-to-back -> second accept exactly one cycle after first wb_done; wb_busy_addr tracks each.
//  6 WB_BRESP_CHECK_EN with d_bresp=2'b10 -> wb_err and wb_done pulse together, one cycle.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared dcache definitions: write-back buffer FSM states and AXI encodings.
package dcache_pkg;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_AW   = 2'd1,
    WB_W    = 2'd2,
    WB_B    = 2'd3
  } wb_state_t;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [2:0] AXI_SIZE_4B     = 3'b010;

endpackage

// File: rtl/dcache_wb_buffer.sv
// Victim / uncached-store buffer between the dcache write-back controller and
// the AXI write channels. Latches one dirty line or one uncached word in a
// single handshake, then issues AW, streams W beats and waits for B.
// Optional macro WB_BRESP_CHECK_EN adds d_bresp and a wb_err pulse.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid is never withdrawn and its payload never changes until
// that edge; ready may be asserted independently of valid.
module dcache_wb_buffer
  import dcache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int AXI_ID     = 0
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         wb_valid,
  output logic                         wb_ready,
  input  logic [ADDR_W-1:0]            wb_addr,
  input  logic [LINE_WORDS*DATA_W-1:0] wb_data,
  input  logic [DATA_W/8-1:0]          wb_strb,
  input  logic                         wb_uncache,
  output logic                         wb_busy,
  output logic [ADDR_W-1:0]            wb_busy_addr,
  output logic                         wb_done,
  output logic                         d_awvalid,
  input  logic                         d_awready,
  output logic [ADDR_W-1:0]            d_awaddr,
  output logic [7:0]                   d_awlen,
  output logic [2:0]                   d_awsize,
  output logic [1:0]                   d_awburst,
  output logic [3:0]                   d_awid,
  output logic                         d_wvalid,
  input  logic                         d_wready,
  output logic [DATA_W-1:0]            d_wdata,
  output logic [DATA_W/8-1:0]          d_wstrb,
  output logic                         d_wlast,
  input  logic                         d_bvalid,
  output logic                         d_bready,
`ifdef WB_BRESP_CHECK_EN
  input  logic [1:0]                   d_bresp,
  output logic                         wb_err,
`endif
  output logic [1:0]                   fsm_state
);

  localparam int STRB_W    = DATA_W / 8;
  localparam int BEAT_W    = $clog2(LINE_WORDS);
  localparam int OFF_W     = $clog2(LINE_WORDS * DATA_W / 8);
  localparam int SIZE_LOG2 = $clog2(STRB_W);

  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  wb_state_t                            state;
  logic      [BEAT_W-1:0]               beat;
  logic      [LINE_WORDS-1:0][DATA_W-1:0] line_q;
  logic      [ADDR_W-1:0]               addr_q;
  logic      [STRB_W-1:0]               strb_q;
  logic                                 unc_q;
  logic                                 done_q;
  logic                                 last_beat;
  logic                                 accept;
`ifdef WB_BRESP_CHECK_EN
  logic                                 err_q;
`endif

  // Accept only in IDLE, and not in the cycle that reports completion, so a
  // waiting requester is taken exactly one cycle after wb_done.
  assign wb_ready  = (state == WB_IDLE) && !done_q;
  assign accept    = wb_valid && wb_ready;
  assign last_beat = (beat == (unc_q ? '0 : LAST_BEAT));

  // Sequencer: latch request, then AW -> W beats -> B, all registered state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= WB_IDLE;
      beat   <= '0;
      line_q <= '0;
      addr_q <= '0;
      strb_q <= '0;
      unc_q  <= 1'b0;
      done_q <= 1'b0;
`ifdef WB_BRESP_CHECK_EN
      err_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef WB_BRESP_CHECK_EN
      err_q  <= 1'b0;
`endif
      case (state)
        WB_IDLE: begin
          if (accept) begin
            // Cached victims are always whole lines: force line alignment.
            addr_q <= wb_uncache ? wb_addr : (wb_addr & LINE_MASK);
            line_q <= wb_data;
            strb_q <= wb_strb;
            unc_q  <= wb_uncache;
            state  <= WB_AW;
          end
        end
        WB_AW: begin
          if (d_awready) begin
            beat  <= '0;
            state <= WB_W;
          end
        end
        WB_W: begin
          if (d_wready) begin
            if (last_beat) state <= WB_B;
            else           beat  <= beat + 1'b1;
          end
        end
        WB_B: begin
          if (d_bvalid) begin
            state  <= WB_IDLE;
            done_q <= 1'b1;
`ifdef WB_BRESP_CHECK_EN
            err_q  <= (d_bresp != AXI_RESP_OKAY);
`endif
          end
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

  // Moore outputs: decoded purely from registers, no input-to-output path.
  assign wb_busy      = (state != WB_IDLE);
  assign wb_busy_addr = addr_q;
  assign wb_done      = done_q;
  assign d_awvalid    = (state == WB_AW);
  assign d_awaddr     = addr_q;
  assign d_awlen      = !wb_busy ? 8'd0 : (unc_q ? 8'd0 : 8'(LINE_WORDS - 1));
  assign d_awsize     = wb_busy ? 3'(SIZE_LOG2) : 3'd0;
  assign d_awburst    = !wb_busy ? 2'b00 : (unc_q ? AXI_BURST_FIXED : AXI_BURST_INCR);
  assign d_awid       = 4'(AXI_ID);
  assign d_wvalid     = (state == WB_W);
  assign d_wdata      = line_q[beat];
  assign d_wstrb      = !wb_busy ? '0 : (unc_q ? strb_q : {STRB_W{1'b1}});
  assign d_wlast      = (state == WB_W) && last_beat;
  assign d_bready     = (state == WB_B);
  assign fsm_state    = state;
`ifdef WB_BRESP_CHECK_EN
  assign wb_err       = err_q;
`endif

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Bench for dcache_wb_buffer: directed requests, a reactive AXI slave and a
// scoreboard monitor. Honours WB_BRESP_CHECK_EN when defined.
module tb_dcache_wb_buffer;

  logic         clk;
  logic         rstn;
  logic         wb_valid;
  logic         wb_ready;
  logic [31:0]  wb_addr;
  logic [127:0] wb_data;
  logic [3:0]   wb_strb;
  logic         wb_uncache;
  logic         wb_busy;
  logic [31:0]  wb_busy_addr;
  logic         wb_done;
  logic         d_awvalid;
  logic         d_awready;
  logic [31:0]  d_awaddr;
  logic [7:0]   d_awlen;
  logic [2:0]   d_awsize;
  logic [1:0]   d_awburst;
  logic [3:0]   d_awid;
  logic         d_wvalid;
  logic         d_wready;
  logic [31:0]  d_wdata;
  logic [3:0]   d_wstrb;
  logic         d_wlast;
  logic         d_bvalid;
  logic         d_bready;
  logic [1:0]   fsm_state;
`ifdef WB_BRESP_CHECK_EN
  logic [1:0]   d_bresp;
  logic         wb_err;
  logic [1:0]   bresp_val;
`endif

  dcache_wb_buffer dut (
    .clk(clk), .rstn(rstn),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_strb(wb_strb), .wb_uncache(wb_uncache), .wb_busy(wb_busy),
    .wb_busy_addr(wb_busy_addr), .wb_done(wb_done),
    .d_awvalid(d_awvalid), .d_awready(d_awready), .d_awaddr(d_awaddr), .d_awlen(d_awlen),
    .d_awsize(d_awsize), .d_awburst(d_awburst), .d_awid(d_awid),
    .d_wvalid(d_wvalid), .d_wready(d_wready), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_wlast(d_wlast), .d_bvalid(d_bvalid), .d_bready(d_bready),
`ifdef WB_BRESP_CHECK_EN
    .d_bresp(d_bresp), .wb_err(wb_err),
`endif
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [48:0] aw_q[$];    // {addr, len, burst, size, id}
  logic [36:0] w_q[$];     // {data, strb, last}
  logic [16:0] done_q[$];  // {latency (0 = not checked), err}
  int          acc_q[$];

  int   w_hs = 0;
  int   last_done_cyc = 0;
  logic b2b_chk = 1'b0;

  // slave configuration
  int   aw_delay = 0;
  int   aw_cnt   = 0;
  logic w_pat_en = 1'b0;
  logic b_early  = 1'b0;
  int   w_idx    = 0;
  logic [3:0] w_pat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reactive AXI slave ----------------
  always @(posedge clk) begin
    #1;
    if (d_awvalid) begin
      d_awready = (aw_cnt >= aw_delay);
      aw_cnt++;
    end else begin
      d_awready = 1'b0;
      aw_cnt = 0;
    end
    if (w_pat_en) begin
      d_wready = w_pat[w_idx % 4];
      if (d_wvalid) w_idx++;
    end else begin
      d_wready = 1'b1;
    end
    d_bvalid = d_bready || (b_early && d_wvalid);
`ifdef WB_BRESP_CHECK_EN
    d_bresp = bresp_val;
`endif
  end

  // ---------------- monitor ----------------
  logic        aw_stall = 1'b0, w_stall = 1'b0, prev_done = 1'b0;
  logic [31:0] aw_prev;
  logic [32:0] w_prev;
  logic [48:0] e_aw;
  logic [36:0] e_w;
  logic [16:0] e_d;
  int          acc_cyc;

  always @(negedge clk) begin
    if (!rstn) begin
      aw_stall  = 1'b0;
      w_stall   = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (wb_valid && wb_ready) begin
        if (b2b_chk) begin
          chk("b2b_accept_cycle", 64'(cyc), 64'(last_done_cyc + 1));
          b2b_chk = 1'b0;
        end
        acc_q.push_back(cyc);
      end
      if (d_awvalid) begin
        if (aw_stall) chk("aw_stable", d_awaddr, aw_prev);
        if (d_awready) begin
          if (aw_q.size() == 0) chk("aw_unexpected", 1, 0);
          else begin
            e_aw = aw_q.pop_front();
            chk("aw_fields", {d_awaddr, d_awlen, d_awburst, d_awsize, d_awid}, e_aw);
            chk("busy_addr", wb_busy_addr, e_aw[48:17]);
            chk("busy", wb_busy, 1);
          end
        end
        aw_stall = !d_awready;
        aw_prev  = d_awaddr;
      end else aw_stall = 1'b0;
      if (d_wvalid) begin
        if (w_stall) chk("w_stable", {d_wdata, d_wlast}, w_prev);
        if (d_wready) begin
          w_hs++;
          if (w_q.size() == 0) chk("w_unexpected", 1, 0);
          else begin
            e_w = w_q.pop_front();
            chk("w_beat", {d_wdata, d_wstrb, d_wlast}, e_w);
          end
        end
        w_stall = !d_wready;
        w_prev  = {d_wdata, d_wlast};
      end else w_stall = 1'b0;
      if (wb_done) begin
        chk("done_single_cycle", prev_done, 0);
        chk("busy_at_done", wb_busy, 0);
        if (done_q.size() == 0 || acc_q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          e_d     = done_q.pop_front();
          acc_cyc = acc_q.pop_front();
          if (e_d[16:1] != 0) chk("done_latency", 64'(cyc - acc_cyc), 64'(e_d[16:1]));
`ifdef WB_BRESP_CHECK_EN
          chk("wb_err", wb_err, e_d[0]);
`endif
        end
        last_done_cyc = cyc;
      end
      prev_done = wb_done;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1. Pushes expectations, then holds the request until accepted.
  task automatic send(input logic [31:0] a, input logic [127:0] d, input logic [3:0] s,
                      input logic u, input int lat, input logic keep);
    int   n;
    int   beats;
    logic err;
    wb_addr = a; wb_data = d; wb_strb = s; wb_uncache = u; wb_valid = 1'b1;
    beats = u ? 1 : 4;
    aw_q.push_back({(u ? a : {a[31:4], 4'h0}), (u ? 8'd0 : 8'd3), (u ? 2'b00 : 2'b01), 3'd2, 4'd0});
    for (int i = 0; i < beats; i++)
      w_q.push_back({d[i*32 +: 32], (u ? s : 4'hF), (i == beats - 1)});
    err = 1'b0;
`ifdef WB_BRESP_CHECK_EN
    err = (bresp_val != 2'b00);
`endif
    done_q.push_back({16'(lat), err});
    n = 0;
    while (!wb_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) chk("accept_timeout", 64'(n), 0);
    @(posedge clk); #1;
    if (!keep) wb_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((aw_q.size() + w_q.size() + done_q.size()) != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", 64'(aw_q.size() + w_q.size() + done_q.size()), 0);
  endtask

  task automatic check_reset_outs();
    chk("rst_wb_ready", wb_ready, 1);
    chk("rst_ctrl_zero", {d_awvalid, d_wvalid, d_bready, wb_busy, wb_done, d_wlast}, 0);
    chk("rst_addr_zero", {d_awaddr, wb_busy_addr}, 0);
    chk("rst_fields_zero", {d_awlen, d_awsize, d_awburst, d_awid, d_wstrb}, 0);
    chk("rst_wdata_zero", d_wdata, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int n;
    wb_valid = 0; wb_addr = 0; wb_data = 0; wb_strb = 0; wb_uncache = 0;
    d_awready = 0; d_wready = 0; d_bvalid = 0;
    w_pat = 4'b1001;  // index 0..3 -> 1,0,0,1
`ifdef WB_BRESP_CHECK_EN
    bresp_val = 2'b00; d_bresp = 2'b00;
`endif
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #1 check_reset_outs();
    repeat (3) @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk); #1;

    // 1: cached line, zero-wait slave
    send(32'h1000_0040, {32'h44, 32'h33, 32'h22, 32'h11}, 4'h0, 1'b0, 7, 1'b0);
    drain();

    // 2: uncached store, partial strobe
    send(32'hBFD0_0004, {32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF}, 4'b0011, 1'b1, 4, 1'b0);
    drain();

    // cached line from unaligned address: alignment
    send(32'h2000_0078, {32'h8, 32'h7, 32'h6, 32'h5}, 4'h3, 1'b0, 7, 1'b0);
    drain();

    // 3: delayed AW, toggling wready, early bvalid
    aw_delay = 5; w_pat_en = 1'b1; w_idx = 0; b_early = 1'b1;
    send(32'h3000_0100, {32'hA4, 32'hA3, 32'hA2, 32'hA1}, 4'h0, 1'b0, 0, 1'b0);
    drain();
    aw_delay = 0; w_pat_en = 1'b0; b_early = 1'b0;

    // 4: async reset in the middle of beat 2
    base = w_hs;
    send(32'h4000_0000, {32'hB4, 32'hB3, 32'hB2, 32'hB1}, 4'h0, 1'b0, 7, 1'b0);
    n = 0;
    while (w_hs < base + 2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("beat2_reached", 64'(w_hs - base), 2);
    #1 rstn = 1'b0;
    w_q.delete(); done_q.delete(); acc_q.delete(); aw_q.delete();
    #1 check_reset_outs();
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk); #1;
    send(32'h5000_0010, {32'hC4, 32'hC3, 32'hC2, 32'hC1}, 4'h0, 1'b0, 7, 1'b0);
    drain();

    // 5: back-to-back with wb_valid held high
    send(32'h6000_0020, {32'hD4, 32'hD3, 32'hD2, 32'hD1}, 4'h0, 1'b0, 7, 1'b1);
    b2b_chk = 1'b1;
    send(32'h7000_0008, {32'h0, 32'h0, 32'h0, 32'hE1}, 4'b1100, 1'b1, 4, 1'b0);
    drain();
    chk("b2b_checked", b2b_chk, 0);

`ifdef WB_BRESP_CHECK_EN
    // 6: error response, then a clean one
    bresp_val = 2'b10;
    send(32'h8000_0030, {32'hF4, 32'hF3, 32'hF2, 32'hF1}, 4'h0, 1'b0, 7, 1'b0);
    drain();
    bresp_val = 2'b00;
    send(32'h8000_0034, {32'h0, 32'h0, 32'h0, 32'hF5}, 4'b0001, 1'b1, 4, 1'b0);
    drain();
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
